imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction-memory write port. It receives a little-endian byte stream over a valid/ready handshake and assembles each group of four bytes into a 32-bit instruction. It writes each instruction into IMEM through the write-enable/address/data port at consecutive word addresses. While loading, it holds the CPU, and the top level muxes imem_addr onto IMEM's pc input whenever cpu_hold=1.

Parameters:
DEPTH, 64, IMEM depth in 32-bit words; legal num_words range is 1..DEPTH
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned
CNT_W, 7, width of the word counters; must satisfy 2^CNT_W > DEPTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  single-cycle request to begin a load; sampled only in IDLE
num_words  in  CNT_W  number of instructions to load; latched on start
byte_valid  in  1  upstream byte available
byte_data  in  8  upstream byte
byte_ready  out  1  loader accepts a byte this cycle
imem_write_en  out  1  IMEM write strobe
imem_addr  out  32  IMEM byte address; word-aligned
imem_wdata  out  32  assembled instruction
cpu_hold  out  1  keeps the CPU stalled/in reset and selects imem_addr onto IMEM pc
busy  out  1  load in progress
done  out  1  one-cycle pulse at end of load, pass or fail
error  out  1  sticky failure flag; cleared by the next accepted start
words_written  out  CNT_W  count of words committed in the current load

Behaviour:
- Reset values: state=IDLE, all outputs 0, internal byte index, word index and shift register cleared.
- States: IDLE, LOAD, WRITE, CHECK (macro only), DONE.
- IDLE:
  - start=1 with 1<=num_words<=DEPTH: latch count, clear error and words_written, go LOAD.
  - start=1 with num_words=0 or >DEPTH: set error=1, go DONE. No IMEM writes occur.
- LOAD:
  - byte_ready=1, busy=1, cpu_hold=1.
  - A byte is accepted when byte_valid and byte_ready are both high.
  - Byte k of the word (k=0..3) goes to bits [8k+7:8k], so the first byte is the LSB.
  - The 4th accepted byte moves the FSM to WRITE on the next cycle.
  - byte_valid=0 simply stalls the FSM; there is no timeout.
- WRITE:
  - Exactly one cycle with imem_write_en=1, imem_addr=BASE_ADDR+4*word_idx, imem_wdata=assembled word, byte_ready=0.
  - Then word_idx and words_written increment.
  - If word_idx+1==count: go DONE (or CHECK when the macro is enabled). Otherwise go back to LOAD.
- Timing: each word costs a minimum of 5 cycles (4 accepted bytes plus the WRITE cycle).
- imem_addr holds its last value outside WRITE. imem_wdata is don't-care outside WRITE and is driven 0.
- DONE: done=1 for one cycle, cpu_hold=0, busy=0, then go IDLE.
- cpu_hold stays 1 from the cycle after start through the last WRITE/CHECK cycle inclusive.
- start asserted outside IDLE is ignored.
- Reset mid-load:
  - The loader returns to IDLE immediately and discards any partial word.
  - No further IMEM writes occur.
  - Words already written are not tracked.
- Address arithmetic is 32-bit and never wraps within the legal range.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN
- Enabled: after the last word, the loader enters CHECK.
  - In CHECK it accepts 4 more bytes (little-endian) as an expected checksum. These bytes are never written to IMEM.
  - The checksum is the modulo-2^32 sum of all loaded words.
  - On mismatch, error=1. Either way the FSM then goes to DONE.
  - cpu_hold stays 1 through CHECK.
- Disabled: no CHECK state and no trailing bytes are consumed. error is set only on an illegal num_words.

Decomposition:
- Package imem_loader_pkg:
  - state enum type
  - BYTES_PER_WORD=4
  - WORD_BYTES_LOG2=2
  - default DEPTH and BASE_ADDR constants
- Sub-module word_assembler: byte-to-word shift register with 2-bit byte counter, handshake gating and word_valid pulse. It is reused by the CHECK path.
- The FSM and address/count logic live in imem_loader.

Test Plan:
1. Load 2 words: start with num_words=2, send bytes 13 01 50 00 93 01 C0 00.
   - WRITE strobes addr 0x0 with 0x00500113 and addr 0x4 with 0x00C00193.
   - done pulses once; words_written=2; error=0.
2. Backpressure: same stream with byte_valid deasserted for 3 cycles between every byte.
   - Identical writes and data.
   - byte_ready=0 during each WRITE cycle; no byte is lost or duplicated.
3. Illegal length: num_words=0, then num_words=65.
   - No imem_write_en ever asserts.
   - error=1 and done pulses for each; cpu_hold never asserts.
4. Reset mid-load: num_words=3, send 6 bytes, then assert reset for 1 cycle.
   - Exactly one write occurs.
   - All outputs are 0 afterwards; a new start loads cleanly from BASE_ADDR.
5. Full depth: num_words=64 with an incrementing pattern.
   - Last write is addr 0xFC.
   - done arrives 64*5+1 cycles after start with zero-stall input.
6. With IMEM_LOADER_CHECKSUM_EN, load words 0x00000001 and 0x00000002.
   - Trailing checksum 0x00000003 gives error=0.
   - Trailing checksum 0x00000004 gives error=1.
   - Checksum bytes never produce an IMEM write.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM loader.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int          BYTES_PER_WORD    = 4;
  localparam int          WORD_BYTES_LOG2   = 2;
  localparam int          DEFAULT_DEPTH     = 64;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam int          DEFAULT_CNT_W     = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

  // Byte address of word idx relative to a word-aligned base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << WORD_BYTES_LOG2);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus IMEM write port; master = loader side, slave = environment side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_write_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_write_en, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_write_en, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word shift register; word_valid pulses in the cycle the 4th byte is accepted
// and word_data already includes that byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        accept_s;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    word_valid = 1'b0;
    accept_s   = enable & byte_valid;
    if (accept_s) begin
      shift_d    = {byte_data, shift_q[31:8]};
      cnt_d      = cnt_q + 2'd1;
      word_valid = (cnt_q == 2'(BYTES_PER_WORD - 1));
    end else begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
    end
  end

  assign word_data = shift_d;

  // Shift register and byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= 32'd0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// IMEM loader: writes a little-endian byte stream into IMEM at consecutive words while holding the CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum of the loaded words.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          CNT_W     = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  imem_loader_if.master    bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] words_written_q, words_written_d;
  logic [CNT_W-1:0] next_idx_s;
  logic             error_q, error_d;
  logic             byte_ready_q, byte_ready_d;
  logic             write_en_q, write_en_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             check_next_s;
  logic             word_valid_s;
  logic [31:0]      word_data_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
`endif

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .enable     (byte_ready_q),
    .byte_valid (bus.byte_valid),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid_s),
    .word_data  (word_data_s)
  );

  assign next_idx_s = words_written_q + CNT_W'(1'b1);

  // Next-state logic; every output is registered from the next state.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    words_written_d = words_written_q;
    error_d         = error_q;
    addr_d          = addr_q;
    wdata_d         = 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d           = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_written_d = {CNT_W{1'b0}};
          if ((num_words != {CNT_W{1'b0}}) && (num_words <= CNT_W'(DEPTH))) begin
            count_d = num_words;
            error_d = 1'b0;
            state_d = ST_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = 32'd0;
`endif
          end else begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (word_valid_s) begin
          state_d = ST_WRITE;
          addr_d  = word_addr(BASE_ADDR, 32'(words_written_q));
          wdata_d = word_data_s;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        words_written_d = next_idx_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + wdata_q;
        if (next_idx_s == count_q) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_LOAD;
        end
`else
        if (next_idx_s == count_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (word_valid_s) begin
          error_d = (word_data_s != sum_q);
          state_d = ST_DONE;
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    check_next_s = (state_d == ST_CHECK);
`else
    check_next_s = 1'b0;
`endif
    byte_ready_d = (state_d == ST_LOAD) | check_next_s;
    write_en_d   = (state_d == ST_WRITE);
    busy_d       = (state_d == ST_LOAD) | (state_d == ST_WRITE) | check_next_s;
    cpu_hold_d   = busy_d;
    done_d       = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      count_q         <= {CNT_W{1'b0}};
      words_written_q <= {CNT_W{1'b0}};
      error_q         <= 1'b0;
      byte_ready_q    <= 1'b0;
      write_en_q      <= 1'b0;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      cpu_hold_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q           <= 32'd0;
`endif
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      words_written_q <= words_written_d;
      error_q         <= error_d;
      byte_ready_q    <= byte_ready_d;
      write_en_q      <= write_en_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      cpu_hold_q      <= cpu_hold_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q           <= sum_d;
`endif
    end
  end

  assign bus.byte_ready    = byte_ready_q;
  assign bus.imem_write_en = write_en_q;
  assign bus.imem_addr     = addr_q;
  assign bus.imem_wdata    = wdata_q;
  assign cpu_hold          = cpu_hold_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign words_written     = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized bench for imem_loader; expected writes are derived from the byte stream.
module tb_imem_loader;

  localparam int          DEPTH = 64;
  localparam int          CNT_W = 7;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int          CHK_CYC = 4;
`else
  localparam int          CHK_CYC = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             cpu_hold, busy, done, error;
  logic [CNT_W-1:0] words_written;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_words     (num_words),
    .bus           (bus),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hold_cnt = 0;
  int bad_ready = 0;
  int timeouts = 0;
  int start_cyc = 0;
  int last_wbase = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stim[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.imem_write_en) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
    if (bus.imem_write_en && bus.byte_ready) bad_ready <= bad_ready + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (cpu_hold) hold_cnt <= hold_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick_stall(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 3;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic pulse_start(input int n);
    start     = 1'b1;
    num_words = CNT_W'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int   budget;
    logic rdy;
    bus.byte_valid = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    budget = 0;
    forever begin
      rdy = bus.byte_ready;
      @(posedge clk); #1;
      if (rdy) break;
      budget = budget + 1;
      if (budget > 200) begin
        timeouts = timeouts + 1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int dbase);
    int budget;
    budget = 0;
    while (done_cnt == dbase && budget < 3000) begin
      @(posedge clk); #1;
      budget = budget + 1;
    end
    if (done_cnt == dbase) timeouts = timeouts + 1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_flags"}, 32'({bus.byte_ready, bus.imem_write_en, cpu_hold, busy, done, error}), 32'd0);
    check({tag, "_addr"}, bus.imem_addr, 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  // Runs one load of stim (4 bytes per word) and compares against the byte-stream model.
  task automatic run_load(input int mode, input logic bad_sum, input int exp_lat);
    int          n, wbase, dbase, hbase, rbase, tbase;
    logic [31:0] w, sum, chk;
    logic        exp_err;
    n = stim.size() / 4;
    wbase = wr_addr.size(); dbase = done_cnt; hbase = hold_cnt;
    rbase = bad_ready; tbase = timeouts;
    sum = 32'd0;
    for (int i = 0; i < n; i++)
      sum = sum + {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
    chk = bad_sum ? sum + 32'd1 : sum;
    exp_err = bad_sum & (CHK_CYC != 0);
    pulse_start(n);
    for (int j = 0; j < stim.size(); j++) send_byte(stim[j], pick_stall(mode));
    if (CHK_CYC != 0) begin
      for (int k = 0; k < 4; k++) send_byte(chk[8*k +: 8], pick_stall(mode));
    end
    bus.byte_valid = 1'b0;
    wait_done(dbase);
    check("no_timeout", 32'(timeouts - tbase), 32'd0);
    check("done_pulses", 32'(done_cnt - dbase), 32'd1);
    check("write_count", 32'(wr_addr.size() - wbase), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (wbase + i < wr_addr.size()) begin
        w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
        check("wr_addr", wr_addr[wbase+i], BASE + 32'(4*i));
        check("wr_data", wr_data[wbase+i], w);
      end
    end
    check("words_written", 32'(words_written), 32'(n));
    check("error", 32'(error), 32'(exp_err));
    check("ready_in_write", 32'(bad_ready - rbase), 32'd0);
    check("hold_cycles", 32'(hold_cnt - hbase), 32'(done_cyc - start_cyc - 1));
    check("idle_after_done", 32'({busy, cpu_hold, done}), 32'd0);
    if (exp_lat >= 0) check("done_latency", 32'(done_cyc - start_cyc), 32'(exp_lat));
    last_wbase = wbase;
  endtask

  initial begin
    int          dbase, hbase, wbase;
    logic [7:0]  part[6];
    logic [7:0]  r;
    int          n;
    reset = 1'b1; start = 1'b0; num_words = '0;
    bus.byte_valid = 1'b0; bus.byte_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_quiet("reset");

    // Two-word load with known encodings.
    stim.delete();
    stim = {8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    run_load(0, 1'b0, 2*5 + 1 + CHK_CYC);
    check("t1_word0", wr_data[last_wbase], 32'h0050_0113);
    check("t1_word1", wr_data[last_wbase+1], 32'h00C0_0193);

    // Same stream with a 3-cycle gap before every byte.
    run_load(1, 1'b0, -1);

    // Illegal lengths: no writes, no hold, error and done.
    for (int t = 0; t < 2; t++) begin
      dbase = done_cnt; hbase = hold_cnt; wbase = wr_addr.size();
      pulse_start(t == 0 ? 0 : DEPTH + 1);
      repeat (3) @(posedge clk);
      #1;
      check("illegal_done", 32'(done_cnt - dbase), 32'd1);
      check("illegal_error", 32'(error), 32'd1);
      check("illegal_writes", 32'(wr_addr.size() - wbase), 32'd0);
      check("illegal_hold", 32'(hold_cnt - hbase), 32'd0);
    end

    // Reset after six bytes of a three-word load.
    wbase = wr_addr.size();
    for (int j = 0; j < 6; j++) part[j] = 8'($urandom);
    pulse_start(3);
    for (int j = 0; j < 6; j++) send_byte(part[j], 0);
    bus.byte_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_writes", 32'(wr_addr.size() - wbase), 32'd1);
    check("rst_wdata", wr_data[wbase], {part[3], part[2], part[1], part[0]});
    check_quiet("after_rst");
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_more_writes", 32'(wr_addr.size() - wbase), 32'd1);
    stim.delete();
    for (int j = 0; j < 4; j++) begin
      r = 8'($urandom);
      stim.push_back(r);
    end
    run_load(0, 1'b0, 5 + 1 + CHK_CYC);

    // Full depth with an incrementing byte pattern.
    stim.delete();
    for (int j = 0; j < 4*DEPTH; j++) stim.push_back(8'(j));
    run_load(0, 1'b0, DEPTH*5 + 1 + CHK_CYC);
    check("last_addr", wr_addr[wr_addr.size()-1], 32'h0000_00FC);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good then bad over words 1 and 2.
    stim.delete();
    stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load(0, 1'b0, 2*5 + 1 + CHK_CYC);
    run_load(0, 1'b1, 2*5 + 1 + CHK_CYC);
`endif

    // Randomized loads with random stalls.
    for (int it = 0; it < 5; it++) begin
      n = int'($urandom_range(1, 8));
      stim.delete();
      for (int j = 0; j < 4*n; j++) begin
        r = 8'($urandom);
        stim.push_back(r);
      end
      run_load(2, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
